// File: rtl/mat_operand_packer_if.sv
// Byte-stream and operand bus between the host/DMA side and the operand packer.
// Optional feature macro: MAT_PACK_ACK_EN adds the res_ack result-consumed signal.
interface mat_operand_packer_if #(
  parameter int unsigned ELEM_W = 8
);
  logic [ELEM_W-1:0]   s_data;
  logic                s_valid;
  logic                s_ready;
  logic [4*ELEM_W-1:0] A;
  logic [4*ELEM_W-1:0] B;
  logic                load;
  logic                busy;
  logic                res_valid;
`ifdef MAT_PACK_ACK_EN
  logic                res_ack;
`endif

  // Host / stream source side.
  modport master (
    output s_data, s_valid,
    input  s_ready, A, B, load, busy, res_valid
`ifdef MAT_PACK_ACK_EN
    , output res_ack
`endif
  );

  // Packer side.
  modport slave (
    input  s_data, s_valid,
    output s_ready, A, B, load, busy, res_valid
`ifdef MAT_PACK_ACK_EN
    , input res_ack
`endif
  );
endinterface

// File: rtl/mat_operand_packer.sv
// mat_operand_packer: collects 8 byte-serial matrix elements (A row-major, then
// B row-major), packs them into the 2x2 multiplier's A/B operand words, pulses
// load for one cycle, waits WAIT_CYCLES for the result and flags res_valid.
// Optional feature macro: MAT_PACK_ACK_EN -- DONE holds until res_ack.
module mat_operand_packer #(
  parameter int unsigned ELEM_W      = 8,
  parameter int unsigned WAIT_CYCLES = 2   // legal range 1..15
) (
  input logic                 clk,
  input logic                 reset,
  mat_operand_packer_if.slave bus
);

  localparam int unsigned STAGE_W = 8 * ELEM_W;
  localparam int unsigned WORD_W  = 4 * ELEM_W;
  localparam logic [3:0]  WAIT_LAST = 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    FILL,
    LOAD,
    COMPUTE,
    DONE
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [STAGE_W-1:0]  stage_q, stage_d;
  logic [WORD_W-1:0]   a_q, a_d;
  logic [WORD_W-1:0]   b_q, b_d;
  logic [3:0]          wait_q, wait_d;

  // State and datapath registers; reset aborts any partial matrix at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FILL;
      cnt_q   <= '0;
      stage_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stage_q <= stage_d;
      a_q     <= a_d;
      b_q     <= b_d;
      wait_q  <= wait_d;
    end
  end

  // Next-state logic: byte shifting in FILL, latency counting in COMPUTE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stage_d = stage_q;
    a_d     = a_q;
    b_d     = b_q;
    wait_d  = wait_q;
    unique case (state_q)
      FILL: begin
        if (bus.s_valid) begin
          stage_d = {stage_q[STAGE_W-ELEM_W-1:0], bus.s_data};
          cnt_d   = cnt_q + 3'd1;
          // The 8th byte is included in the copy to A/B on the same edge.
          if (cnt_q == 3'd7) begin
            a_d     = stage_d[STAGE_W-1:WORD_W];
            b_d     = stage_d[WORD_W-1:0];
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        wait_d  = '0;
        state_d = COMPUTE;
      end
      COMPUTE: begin
        if (wait_q == WAIT_LAST) begin
          state_d = DONE;
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      DONE: begin
`ifdef MAT_PACK_ACK_EN
        if (bus.res_ack) begin
          state_d = FILL;
        end
`else
        state_d = FILL;
`endif
      end
      default: state_d = FILL;
    endcase
  end

  // Handshake and status outputs decode from state only; no s_valid -> s_ready path.
  assign bus.s_ready   = (state_q == FILL);
  assign bus.load      = (state_q == LOAD);
  assign bus.busy      = (state_q != FILL);
  assign bus.res_valid = (state_q == DONE);
  assign bus.A         = a_q;
  assign bus.B         = b_q;

endmodule
